// File: rtl/vga_rx_monitor.sv
// VGA receive-side timing monitor: measures line/frame timing, tracks lock,
// and optionally CRCs active pixels when VGA_RX_CRC_EN is defined.
module vga_rx_monitor #(
  parameter int CW   = 12,
  parameter bit HPOL = 1'b0,
  parameter bit VPOL = 1'b0
) (
  input  logic          pclk,
  input  logic          act_reset,
  input  logic          vga_h,
  input  logic          vga_v,
  input  logic          vga_de,
  input  logic [3:0]    vga_r,
  input  logic [3:0]    vga_g,
  input  logic [3:0]    vga_b,
  output logic [CW-1:0] htotal,
  output logic [CW-1:0] hsync_w,
  output logic [CW-1:0] hactive,
  output logic [CW-1:0] vtotal,
  output logic [CW-1:0] vsync_w,
  output logic [CW-1:0] vactive,
  output logic [15:0]   frame_crc,
  output logic          meas_valid,
  output logic          locked,
  output logic          timeout
);

  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] ONE = 1;

  typedef enum logic [1:0] {
    SEEK,
    MEASURE,
    TRACK
  } state_t;

  state_t state, state_n;

  logic h_q, v_q, de_q;
  logic hs_prev, vs_prev;
  logic hs_act, vs_act;
  logic h_lead, v_lead;

  logic [CW-1:0] hcnt, hw_cnt, de_cnt;
  logic [CW-1:0] htot_c, hw_c;
  logic [CW-1:0] vcnt, vw_cnt, va_cnt, hact_acc;
  logic          lflag, got;

  logic [CW-1:0] hcnt_n, vcnt_i;
  logic [CW-1:0] htot_e, hw_e, hact_e;
  logic [CW-1:0] vw_e, va_e;
  logic          got_e;
  logic          sat, do_meas;

  logic [6*CW-1:0] tuple_e, prev;
  logic [1:0]      match_cnt;

  function automatic logic [CW-1:0] inc(
    input logic [CW-1:0] x
  );
    return (x == MAX) ? x : x + ONE;
  endfunction

  // "_e" values: accumulators with the current line end applied
  always_comb begin
    hs_act  = (h_q == HPOL);
    vs_act  = (v_q == VPOL);
    h_lead  = hs_act & ~hs_prev;
    v_lead  = vs_act & ~vs_prev;
    hcnt_n  = h_lead ? ONE : inc(hcnt);
    vcnt_i  = h_lead ? inc(vcnt) : vcnt;
    htot_e  = h_lead ? hcnt : htot_c;
    hw_e    = h_lead ? hw_cnt : hw_c;
    vw_e    = (h_lead && vs_act) ?
              inc(vw_cnt) : vw_cnt;
    va_e    = (h_lead && lflag) ?
              inc(va_cnt) : va_cnt;
    hact_e  = (h_lead && lflag && !got) ?
              de_cnt : hact_acc;
    got_e   = got | (h_lead & lflag);
    tuple_e = {htot_e, hw_e, hact_e,
               vcnt_i, vw_e, va_e};
    sat     = (hcnt_n == MAX && hcnt != MAX) ||
              (vcnt_i == MAX && vcnt != MAX);
  end

  always_ff @(posedge pclk) begin
    if (act_reset) state <= SEEK;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    do_meas = 1'b0;
    if (sat) begin
      state_n = SEEK;
    end else begin
      unique case (state)
        SEEK:    if (v_lead) state_n = MEASURE;
        MEASURE: if (v_lead) begin
          state_n = TRACK;
          do_meas = 1'b1;
        end
        TRACK:   if (v_lead) do_meas = 1'b1;
        default: state_n = SEEK;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (act_reset) begin
      h_q        <= HPOL;
      v_q        <= VPOL;
      de_q       <= 1'b0;
      hs_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      hcnt       <= '0;
      hw_cnt     <= '0;
      de_cnt     <= '0;
      htot_c     <= '0;
      hw_c       <= '0;
      lflag      <= 1'b0;
      vcnt       <= '0;
      vw_cnt     <= '0;
      va_cnt     <= '0;
      hact_acc   <= '0;
      got        <= 1'b0;
      htotal     <= '0;
      hsync_w    <= '0;
      hactive    <= '0;
      vtotal     <= '0;
      vsync_w    <= '0;
      vactive    <= '0;
      prev       <= '0;
      match_cnt  <= 2'd0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      h_q     <= vga_h;
      v_q     <= vga_v;
      de_q    <= vga_de;
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      hcnt    <= hcnt_n;
      hw_cnt  <= h_lead ? ONE :
                 (hs_act ? inc(hw_cnt) : hw_cnt);
      htot_c  <= htot_e;
      hw_c    <= hw_e;
      if (h_lead) begin
        de_cnt <= de_q ? ONE : '0;
        lflag  <= de_q;
      end else if (de_q) begin
        de_cnt <= inc(de_cnt);
        lflag  <= 1'b1;
      end
      if (v_lead) begin
        vcnt     <= '0;
        vw_cnt   <= '0;
        va_cnt   <= '0;
        hact_acc <= '0;
        got      <= 1'b0;
      end else begin
        vcnt     <= vcnt_i;
        vw_cnt   <= vw_e;
        va_cnt   <= va_e;
        hact_acc <= hact_e;
        got      <= got_e;
      end
      meas_valid <= do_meas;
      timeout    <= sat;
      if (sat) begin
        locked    <= 1'b0;
        match_cnt <= 2'd0;
      end else if (do_meas) begin
        {htotal, hsync_w, hactive,
         vtotal, vsync_w, vactive} <= tuple_e;
        prev <= tuple_e;
        // lock needs a match while match_cnt is already 2
        if (tuple_e == prev) begin
          locked    <= (match_cnt == 2'd2);
          match_cnt <= (match_cnt == 2'd2) ?
                       2'd2 : match_cnt + 2'd1;
        end else begin
          locked    <= 1'b0;
          match_cnt <= 2'd0;
        end
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [11:0] rgb_q;
  logic [15:0] crc_acc;

  function automatic logic [15:0] crc12(
    input logic [15:0] c,
    input logic [11:0] d
  );
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge pclk) begin
    if (act_reset) begin
      rgb_q     <= '0;
      crc_acc   <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      rgb_q <= {vga_r, vga_g, vga_b};
      if (v_lead)
        crc_acc <= de_q ? crc12(16'hFFFF, rgb_q) :
                   16'hFFFF;
      else if (de_q)
        crc_acc <= crc12(crc_acc, rgb_q);
      if (do_meas) frame_crc <= crc_acc;
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^{vga_r, vga_g, vga_b};
  assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor: small video timing, both sync
// polarities, lock/relock, timeout, mid-frame reset and frame CRC.
module tb_vga_rx_monitor;

  localparam int HT = 20;
  localparam int HS = 3;
  localparam int VT = 10;
  localparam int VS = 2;
`ifdef VGA_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef struct {
    int          frame;
    logic [11:0] ht, hw, ha, vt, vw, va;
    logic [15:0] crc;
    logic        lk;
  } rec_t;

  typedef struct {
    int frame;
    int ht;
    bit lk;
    bit flip;
  } exp_t;

  logic pclk = 1'b0;
  logic act_reset;
  logic vga_h, vga_v, vga_de;
  logic [3:0] vga_r, vga_g, vga_b;
  logic h_inv, v_inv;

  logic [11:0] ht0, hw0, ha0, vt0, vw0, va0;
  logic [11:0] ht1, hw1, ha1, vt1, vw1, va1;
  logic [15:0] crc0, crc1;
  logic mv0, lk0, to0, mv1, lk1, to1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cur_frame = 0;
  int last_lead = 0;
  int to_n0 = 0, to_n1 = 0;
  int to_cyc0 = 0, to_cyc1 = 0;
  rec_t q0[$];
  rec_t q1[$];
  exp_t tbl[16];
  logic [15:0] crc_norm, crc_flip;

  assign h_inv = ~vga_h;
  assign v_inv = ~vga_v;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  vga_rx_monitor u_dut0 (
    .pclk(pclk), .act_reset(act_reset),
    .vga_h(vga_h), .vga_v(vga_v),
    .vga_de(vga_de), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b),
    .htotal(ht0), .hsync_w(hw0),
    .hactive(ha0), .vtotal(vt0),
    .vsync_w(vw0), .vactive(va0),
    .frame_crc(crc0), .meas_valid(mv0),
    .locked(lk0), .timeout(to0)
  );

  vga_rx_monitor #(.HPOL(1'b1), .VPOL(1'b1)) u_dut1 (
    .pclk(pclk), .act_reset(act_reset),
    .vga_h(h_inv), .vga_v(v_inv),
    .vga_de(vga_de), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b),
    .htotal(ht1), .hsync_w(hw1),
    .hactive(ha1), .vtotal(vt1),
    .vsync_w(vw1), .vactive(va1),
    .frame_crc(crc1), .meas_valid(mv1),
    .locked(lk1), .timeout(to1)
  );

  always @(negedge pclk) begin
    if (mv0) q0.push_back('{cur_frame, ht0, hw0, ha0,
                            vt0, vw0, va0, crc0, lk0});
    if (mv1) q1.push_back('{cur_frame, ht1, hw1, ha1,
                            vt1, vw1, va1, crc1, lk1});
    if (to0) begin to_n0++; to_cyc0 = cyc; end
    if (to1) begin to_n1++; to_cyc1 = cyc; end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_word(
    input logic [15:0] c, input logic [11:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--)
      r = (r[15] ^ w[i]) ? ((r << 1) ^ 16'h1021) :
          (r << 1);
    return r;
  endfunction

  function automatic logic [11:0] pix(
    input int l, input int h, input bit flip);
    if (flip && l == 4 && h == 7) return 12'h0F0;
    return 12'hF00;
  endfunction

  function automatic bit de_at(input int l, input int h);
    return (l >= 3 && l <= 8 && h >= 5 && h <= 16);
  endfunction

  function automatic logic [15:0] frame_model(input bit flip);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int l = 0; l < VT; l++)
      for (int h = 0; h < HT; h++)
        if (de_at(l, h)) c = crc_word(c, pix(l, h, flip));
    return c;
  endfunction

  task automatic zero_chk(input string nm);
    chk({nm, ".ht0"}, ht0, 0);
    chk({nm, ".vt0"}, vt0, 0);
    chk({nm, ".va0"}, va0, 0);
    chk({nm, ".crc0"}, crc0, 0);
    chk({nm, ".lk0"}, lk0, 0);
    chk({nm, ".mv0"}, mv0, 0);
    chk({nm, ".to0"}, to0, 0);
    chk({nm, ".ht1"}, ht1, 0);
    chk({nm, ".lk1"}, lk1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      vga_h = 1'b1; vga_v = 1'b1; vga_de = 1'b0;
    end
  endtask

  task automatic drive_frame(input int last_h,
                             input bit flip,
                             input bit rst_mid);
    cur_frame++;
    for (int l = 0; l < VT; l++) begin
      int hl;
      hl = (l == VT - 1) ? last_h : HT;
      for (int h = 0; h < hl; h++) begin
        logic [11:0] c;
        @(negedge pclk);
        if (rst_mid && l == 5 && h == 1) begin
          zero_chk("mid_reset");
          act_reset = 1'b0;
        end
        if (rst_mid && l == 5 && h == 0)
          act_reset = 1'b1;
        c = pix(l, h, flip);
        vga_h  = !(h < HS);
        vga_v  = !(l < VS);
        vga_de = de_at(l, h);
        {vga_r, vga_g, vga_b} = c;
        if (h == 0) last_lead = cyc;
      end
    end
  endtask

  task automatic check_rec(input string nm,
                           input rec_t r,
                           input exp_t e);
    logic [15:0] ec;
    ec = CRC_ON ? (e.flip ? crc_flip : crc_norm) : 16'h0;
    chk({nm, ".frame"}, r.frame, e.frame);
    chk({nm, ".htotal"}, r.ht, e.ht);
    chk({nm, ".hsync_w"}, r.hw, HS);
    chk({nm, ".hactive"}, r.ha, 12);
    chk({nm, ".vtotal"}, r.vt, VT);
    chk({nm, ".vsync_w"}, r.vw, VS);
    chk({nm, ".vactive"}, r.va, 6);
    chk({nm, ".locked"}, r.lk, e.lk);
    chk({nm, ".crc"}, r.crc, ec);
  endtask

  initial begin
    tbl[0]  = '{2, 20, 0, 0};
    tbl[1]  = '{3, 20, 0, 0};
    tbl[2]  = '{4, 20, 0, 0};
    tbl[3]  = '{5, 20, 1, 0};
    tbl[4]  = '{6, 20, 1, 0};
    tbl[5]  = '{7, 20, 1, 0};
    tbl[6]  = '{8, 21, 0, 0};
    tbl[7]  = '{9, 20, 0, 0};
    tbl[8]  = '{10, 20, 0, 0};
    tbl[9]  = '{11, 20, 0, 0};
    tbl[10] = '{12, 20, 1, 0};
    tbl[11] = '{13, 20, 1, 1};
    tbl[12] = '{14, 20, 1, 0};
    tbl[13] = '{16, 20, 0, 0};
    tbl[14] = '{17, 20, 0, 0};
    tbl[15] = '{19, 20, 0, 0};
    crc_norm = frame_model(1'b0);
    crc_flip = frame_model(1'b1);

    act_reset = 1'b1;
    vga_h = 1'b1; vga_v = 1'b1; vga_de = 1'b0;
    {vga_r, vga_g, vga_b} = 12'h000;
    repeat (3) @(negedge pclk);
    zero_chk("reset");
    act_reset = 1'b0;

    for (int f = 1; f <= 6; f++) drive_frame(HT, 0, 0);
    drive_frame(HT + 1, 0, 0);
    for (int f = 8; f <= 11; f++) drive_frame(HT, 0, 0);
    drive_frame(HT, 1, 0);
    drive_frame(HT, 0, 0);
    drive_frame(HT, 0, 0);

    idle(4300);
    chk("timeout_count0", to_n0, 1);
    chk("timeout_count1", to_n1, 1);
    chk("timeout_delay0", to_cyc0 - last_lead, 4096);
    chk("timeout_delay1", to_cyc1 - last_lead, 4096);
    chk("timeout_unlock0", lk0, 0);
    chk("timeout_unlock1", lk1, 0);
    chk("timeout_nomeas0", q0.size(), 13);

    drive_frame(HT, 0, 0);
    drive_frame(HT, 0, 0);
    drive_frame(HT, 0, 1);
    drive_frame(HT, 0, 0);
    drive_frame(HT, 0, 0);
    idle(10);

    chk("meas_count0", q0.size(), 16);
    chk("meas_count1", q1.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < q0.size())
        check_rec($sformatf("d0[%0d]", i), q0[i], tbl[i]);
      if (i < q1.size())
        check_rec($sformatf("d1[%0d]", i), q1[i], tbl[i]);
    end
    if (q0.size() > 11)
      chk("crc_flip_differs",
          q0[11].crc != q0[10].crc, CRC_ON);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
